// File: rtl/lane_merge_arbiter.sv
// -----------------------------------------------------------------------------
// lane_merge_arbiter
//
// Two-source round-robin arbiter with a single registered output word. When
// both sources offer data the source not granted last wins. An optional
// lane-merge mode builds one word from both sources, taking each lane from A
// or from B according to lane_mask. Merging is compiled in only when the
// macro LANE_MERGE_EN is defined; otherwise merge_req and lane_mask are
// accepted but ignored.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   a_valid    in   1      source A offers a word
//   a_data     in   WIDTH  source A word
//   a_ready    out  1      source A word consumed this cycle (combinational)
//   b_valid    in   1      source B offers a word
//   b_data     in   WIDTH  source B word
//   b_ready    out  1      source B word consumed this cycle (combinational)
//   merge_req  in   1      request a lane-merge of A and B
//   lane_mask  in   WIDTH  per-lane merge select: 1 = A, 0 = B
//   out_valid  out  1      sink word valid (registered)
//   out_data   out  WIDTH  sink word (registered)
//   out_src    out  2      origin of sink word: 01 = A, 10 = B, 11 = merged
//   out_ready  in   1      sink accepts the word
// -----------------------------------------------------------------------------
module lane_merge_arbiter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  input  logic             merge_req,
  input  logic [WIDTH-1:0] lane_mask,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_A     = 2'b01;
  localparam logic [1:0] SRC_B     = 2'b10;
  localparam logic [1:0] SRC_MERGE = 2'b11;

  // Pointer records the source granted in the last contention.
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [1:0]       out_src_r;
  logic             ptr_r;

  logic             load_s;
  logic             merge_s;
  logic [WIDTH-1:0] merge_data_s;
  logic             contend_s;
  logic             sel_a_s;
  logic             sel_b_s;
  logic [WIDTH-1:0] next_data_s;
  logic [1:0]       next_src_s;

  // The output register may take a new word when empty or being drained.
  assign load_s = !out_valid_r || out_ready;

`ifdef LANE_MERGE_EN
  assign merge_s      = a_valid && b_valid && merge_req;
  // Pure per-lane mux: lane i only sees lane i of a_data, b_data, lane_mask.
  assign merge_data_s = (a_data & lane_mask) | (b_data & ~lane_mask);
`else
  logic unused_merge_s;
  assign unused_merge_s = merge_req ^ (^lane_mask);
  assign merge_s        = 1'b0;
  assign merge_data_s   = {WIDTH{1'b0}};
`endif

  // Source selection and next output word for this cycle.
  always_comb begin
    sel_a_s     = 1'b0;
    sel_b_s     = 1'b0;
    contend_s   = 1'b0;
    next_data_s = out_data_r;
    next_src_s  = out_src_r;
    if (merge_s) begin
      sel_a_s     = 1'b1;
      sel_b_s     = 1'b1;
      next_data_s = merge_data_s;
      next_src_s  = SRC_MERGE;
    end else if (a_valid && b_valid) begin
      contend_s = 1'b1;
      if (ptr_r == PTR_B) begin
        sel_a_s     = 1'b1;
        next_data_s = a_data;
        next_src_s  = SRC_A;
      end else begin
        sel_b_s     = 1'b1;
        next_data_s = b_data;
        next_src_s  = SRC_B;
      end
    end else if (a_valid) begin
      sel_a_s     = 1'b1;
      next_data_s = a_data;
      next_src_s  = SRC_A;
    end else if (b_valid) begin
      sel_b_s     = 1'b1;
      next_data_s = b_data;
      next_src_s  = SRC_B;
    end else begin
      // Nothing offered: data and origin hold, only out_valid drops.
      next_data_s = out_data_r;
      next_src_s  = out_src_r;
    end
  end

  // Gating with rst keeps both readys low for the whole reset window.
  assign a_ready = !rst && load_s && sel_a_s;
  assign b_ready = !rst && load_s && sel_b_s;

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_src_r   <= SRC_NONE;
      ptr_r       <= PTR_B;
    end else if (load_s) begin
      out_valid_r <= sel_a_s || sel_b_s;
      out_data_r  <= next_data_s;
      out_src_r   <= next_src_s;
      // Only a plain contention moves the pointer; merges and lone requests leave it.
      if (contend_s) begin
        ptr_r <= sel_a_s ? PTR_A : PTR_B;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;

endmodule

// File: tb/tb_lane_merge_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lane_merge_arbiter
//
// Directed self-checking bench for lane_merge_arbiter with WIDTH = 2. Inputs
// change 1 time unit after a rising edge; combinational readys are sampled
// 1 unit later and registered outputs 1 unit after the following edge.
// Honours LANE_MERGE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_lane_merge_arbiter;

  localparam int WIDTH = 2;

  logic             clk;
  logic             rst;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             merge_req;
  logic [WIDTH-1:0] lane_mask;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  int total = 0;
  int bad   = 0;

  lane_merge_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .merge_req (merge_req),
    .lane_mask (lane_mask),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Output word left in the register after the merge section, and the
  // source that wins the next contention.
`ifdef LANE_MERGE_EN
  localparam logic [1:0] HELD_DATA = 2'b10;
  localparam logic [1:0] HELD_SRC  = 2'b01;
  localparam bit         NEXT_IS_A = 1'b0;
`else
  localparam logic [1:0] HELD_DATA = 2'b01;
  localparam logic [1:0] HELD_SRC  = 2'b10;
  localparam bit         NEXT_IS_A = 1'b1;
`endif

  initial begin
    bit exp_a;

    rst       = 1'b1;
    a_valid   = 1'b0;
    a_data    = 2'b00;
    b_valid   = 1'b0;
    b_data    = 2'b00;
    merge_req = 1'b0;
    lane_mask = 2'b00;
    out_ready = 1'b0;

    // Reset state, and no ready while reset is held even with a request.
    #2;
    chk("rst_valid", 8'(out_valid), 8'h0);
    chk("rst_data",  8'(out_data),  8'h0);
    chk("rst_src",   8'(out_src),   8'h0);
    a_valid   = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst_a_ready", 8'(a_ready), 8'h0);

    // Single source A; first load on the first edge after release.
    tick();
    rst    = 1'b0;
    a_data = 2'b10;
    #1;
    chk("single_a_ready", 8'(a_ready), 8'h1);
    chk("single_b_ready", 8'(b_ready), 8'h0);
    tick();
    chk("single_valid", 8'(out_valid), 8'h1);
    chk("single_data",  8'(out_data),  8'h2);
    chk("single_src",   8'(out_src),   8'h1);

    // Contention: A, B, A, B.
    b_valid = 1'b1;
    a_data  = 2'b01;
    b_data  = 2'b10;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      chk("rr_a_ready", 8'(a_ready), 8'(exp_a));
      chk("rr_b_ready", 8'(b_ready), 8'(!exp_a));
      tick();
      chk("rr_src",  8'(out_src),  exp_a ? 8'h1 : 8'h2);
      chk("rr_data", 8'(out_data), exp_a ? 8'h1 : 8'h2);
    end

    // Merge request: a=10, b=01, mask=10.
    a_data    = 2'b10;
    b_data    = 2'b01;
    lane_mask = 2'b10;
    merge_req = 1'b1;
`ifdef LANE_MERGE_EN
    #1;
    chk("mrg_a_ready", 8'(a_ready), 8'h1);
    chk("mrg_b_ready", 8'(b_ready), 8'h1);
    tick();
    chk("mrg_data", 8'(out_data), 8'h3);
    chk("mrg_src",  8'(out_src),  8'h3);
    merge_req = 1'b0;
    #1;
    chk("mrg_next_a_ready", 8'(a_ready), 8'h1);
    chk("mrg_next_b_ready", 8'(b_ready), 8'h0);
    tick();
    chk("mrg_next_src",  8'(out_src),  8'h1);
    chk("mrg_next_data", 8'(out_data), 8'h2);
`else
    #1;
    chk("nomrg_a_ready", 8'(a_ready), 8'h1);
    chk("nomrg_b_ready", 8'(b_ready), 8'h0);
    tick();
    chk("nomrg_data1", 8'(out_data), 8'h2);
    chk("nomrg_src1",  8'(out_src),  8'h1);
    #1;
    chk("nomrg_b_ready2", 8'(b_ready), 8'h1);
    tick();
    chk("nomrg_data2", 8'(out_data), 8'h1);
    chk("nomrg_src2",  8'(out_src),  8'h2);
    merge_req = 1'b0;
`endif

    // Backpressure for 3 cycles with both sources valid.
    a_data    = 2'b11;
    b_data    = 2'b00;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_a_ready", 8'(a_ready), 8'h0);
      chk("bp_b_ready", 8'(b_ready), 8'h0);
      tick();
      chk("bp_valid", 8'(out_valid), 8'h1);
      chk("bp_data",  8'(out_data),  8'(HELD_DATA));
      chk("bp_src",   8'(out_src),   8'(HELD_SRC));
    end

    // Release: round-robin picks up where it left off.
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_a = (i == 0) ? NEXT_IS_A : !NEXT_IS_A;
      #1;
      chk("rel_a_ready", 8'(a_ready), 8'(exp_a));
      chk("rel_b_ready", 8'(b_ready), 8'(!exp_a));
      tick();
      chk("rel_src",  8'(out_src),  exp_a ? 8'h1 : 8'h2);
      chk("rel_data", 8'(out_data), exp_a ? 8'h3 : 8'h0);
    end

    // Nothing offered: valid drops, data and origin hold (last grant was B when
    // NEXT_IS_A, else A).
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    chk("idle_valid", 8'(out_valid), 8'h0);
    chk("idle_data",  8'(out_data),  NEXT_IS_A ? 8'h0 : 8'h3);
    chk("idle_src",   8'(out_src),   NEXT_IS_A ? 8'h2 : 8'h1);

    // Single source B.
    b_valid = 1'b1;
    b_data  = 2'b01;
    #1;
    chk("single_b_ready", 8'(b_ready), 8'h1);
    tick();
    chk("single_b_data", 8'(out_data), 8'h1);
    chk("single_b_src",  8'(out_src),  8'h2);

    // Stall with a word held, then reset mid-transfer.
    b_valid   = 1'b0;
    a_valid   = 1'b1;
    a_data    = 2'b10;
    out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 8'(out_valid), 8'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid",   8'(out_valid), 8'h0);
    chk("mid_rst_data",    8'(out_data),  8'h0);
    chk("mid_rst_src",     8'(out_src),   8'h0);
    chk("mid_rst_a_ready", 8'(a_ready),   8'h0);
    chk("mid_rst_b_ready", 8'(b_ready),   8'h0);

    // Release: the empty register loads on the first edge.
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", 8'(a_ready), 8'h1);
    tick();
    chk("post_rst_valid", 8'(out_valid), 8'h1);
    chk("post_rst_data",  8'(out_data),  8'h2);
    chk("post_rst_src",   8'(out_src),   8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_merge_arbiter.md
LANE_MERGE_ARBITER -- requirements
Module: lane_merge_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the bit width of each source bus and of the sink bus.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named as the codebase names them: clk and rst.
REQ-003 The block SHALL have the following ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- a_valid  input  1  source A offers data.
- a_data  input  WIDTH  source A bus.
- a_ready  output  1  source A word consumed this cycle.
- b_valid  input  1  source B offers data.
- b_data  input  WIDTH  source B bus.
- b_ready  output  1  source B word consumed this cycle.
- merge_req  input  1  request a lane-merge of A and B.
- lane_mask  input  WIDTH  per-lane source select for merge: 1 = A, 0 = B.
- out_valid  output  1  sink word valid.
- out_data  output  WIDTH  sink bus (registered).
- out_src  output  2  origin of the sink word: 01 = A, 10 = B, 11 = merged.
- out_ready  input  1  sink accepts the word.

Function
REQ-004 The block SHALL define load = !out_valid || out_ready; the output register SHALL update only in a cycle where load = 1.
REQ-005 a_ready and b_ready SHALL be combinational, asserted only when load = 1 and the corresponding source is selected that cycle.
REQ-006 The block SHALL use merge selection when load = 1, a_valid = b_valid = 1, merge_req = 1 and the merge feature is compiled in.
- out_data <= (a_data & lane_mask) | (b_data & ~lane_mask).
- out_src <= 11.
- a_ready = b_ready = 1.
- The round-robin pointer SHALL NOT change.
REQ-007 Otherwise, with exactly one source valid, that source SHALL be selected: out_data <= its data, out_src <= 01 or 10.
REQ-008 Otherwise, with both sources valid, the block SHALL grant the source not granted last (round-robin pointer); the pointer SHALL update to the granted source.
REQ-009 With no source valid and load = 1, out_valid SHALL go to 0 and out_data/out_src SHALL hold their values.
REQ-010 Latency SHALL be 1 cycle from accept to out_valid; sustained throughput SHALL be one word per cycle when out_ready = 1.
REQ-011 While out_valid = 1 and out_ready = 0, out_data, out_src and out_valid SHALL remain stable, and a_ready = b_ready = 0.
REQ-012 Selection SHALL be bit-exact per lane with no arithmetic and no width extension; lane i of out_data SHALL depend only on lane i of the inputs.
REQ-013 A source whose valid drops without ready SHALL be treated as not requesting; the block SHALL store no per-source state other than the pointer.

Reset
REQ-014 On rst = 1, asynchronously: out_valid = 0, out_data = 0, out_src = 00, pointer = B (so A wins the first contention).
REQ-015 While rst = 1, a_ready and b_ready SHALL be 0.
REQ-016 Reset asserted mid-transfer SHALL discard the held word with no ready pulse to either source.
REQ-017 The first load SHALL be possible in the first rising edge after rst deasserts.

Configuration
REQ-018 The merge feature SHALL be compiled in by macro LANE_MERGE_EN.
- Defined: REQ-006 applies.
- Undefined: merge_req and lane_mask SHALL remain as ports but be ignored; both-valid cases SHALL always follow REQ-008, and out_src SHALL never be 11.

Verification
REQ-019 Reset check: assert rst mid-transfer with out_valid = 1 -> out_valid = 0, out_data = 00, out_src = 00 immediately, with no ready pulse.
REQ-020 Single source: WIDTH = 2, a_valid = 1, a_data = 10, out_ready = 1 -> a_ready = 1 that cycle; next cycle out_data = 10, out_src = 01.
REQ-021 Contention: a_valid = b_valid = 1 held for 4 cycles, merge_req = 0, out_ready = 1 -> grants A, B, A, B; out_src 01, 10, 01, 10.
REQ-022 Merge (LANE_MERGE_EN defined): a_data = 10, b_data = 01, lane_mask = 10, merge_req = 1 -> out_data = 11, out_src = 11, both ready pulse once; next contention grants A.
REQ-023 Backpressure: out_ready = 0 for 3 cycles with both sources valid -> out_data stable, a_ready = b_ready = 0; releasing out_ready resumes the round-robin order with no word lost or duplicated.
REQ-024 Merge compiled out: repeat REQ-022 -> A granted (out_data = 10, out_src = 01), then B (out_data = 01, out_src = 10).
